// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 encodings, FSM states, M/WB payload.
package mem_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUS  = 1'b1;

  typedef struct packed {
    logic            valid;
    logic            reg_wr;
    logic [4:0]      reg_wnum;
    logic            mem_load;
    logic [XLEN-1:0] mem_dat;
    logic [XLEN-1:0] aluresult;
    logic [XLEN-1:0] data_out;
  } wb_payload_t;

  // Half-word needs addr[0]==0, word needs addr[1:0]==0; undefined sizes count as word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = lane[0];
      default: is_misaligned = (lane != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational load extraction/extension and store byte-enable/data replication.
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      lane_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] load_data_i,
  output logic [XLEN-1:0] load_ext_o,
  output logic [3:0]      sel_o,
  output logic [XLEN-1:0] store_dat_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    case (lane_i)
      2'd0:    byte_c = load_data_i[7:0];
      2'd1:    byte_c = load_data_i[15:8];
      2'd2:    byte_c = load_data_i[23:16];
      default: byte_c = load_data_i[31:24];
    endcase
    half_c = lane_i[1] ? load_data_i[31:16] : load_data_i[15:0];
  end

  // funct3[2] selects zero extension; sizes other than byte/half fall back to word.
  always_comb begin
    load_ext_o  = load_data_i;
    sel_o       = 4'b1111;
    store_dat_o = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        load_ext_o  = funct3_i[2] ? {{(XLEN-8){1'b0}}, byte_c} : {{(XLEN-8){byte_c[7]}}, byte_c};
        sel_o       = 4'b0001 << lane_i;
        store_dat_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        load_ext_o  = funct3_i[2] ? {{(XLEN-16){1'b0}}, half_c} : {{(XLEN-16){half_c[15]}}, half_c};
        sel_o       = 4'b0011 << {lane_i[1], 1'b0};
        store_dat_o = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// rv32 memory-access stage: pass-through for ALU ops, single Wishbone-classic cycle per load/store.
// Optional MEM_MISALIGN_EN: trap misaligned half/word accesses instead of issuing them.
module mem_lsu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_aluresult,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [XLEN-1:0] ex_data_out,
  input  logic            ex_mem_load,
  input  logic            ex_mem_store,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_reg_wr,
  input  logic [4:0]      ex_reg_wnum,
  output logic            wb_valid,
  output logic            wb_reg_wr,
  output logic [4:0]      wb_reg_wnum,
  output logic            wb_mem_load,
  output logic [XLEN-1:0] wb_mem_dat_i_w,
  output logic [XLEN-1:0] wb_aluresult,
  output logic [XLEN-1:0] wb_data_out,
  output logic            dbus_cyc_o,
  output logic            dbus_stb_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_adr_o,
  output logic [XLEN-1:0] dbus_dat_o,
  output logic [3:0]      dbus_sel_o,
  input  logic [XLEN-1:0] dbus_dat_i,
  input  logic            dbus_ack_i,
  input  logic            dbus_err_i,
  output logic            bus_err_o,
  output logic            misalign_o
);
  import mem_pkg::*;

  logic [0:0]      state_q, state_d;
  wb_payload_t     wb_q, wb_d;
  logic            cyc_q, cyc_d, we_q, we_d;
  logic [XLEN-1:0] badr_q, badr_d, bdat_q, bdat_d;
  logic [3:0]      bsel_q, bsel_d;
  logic [XLEN-1:0] addr_q, addr_d, dout_q, dout_d;
  logic [2:0]      f3_q, f3_d;
  logic            ld_q, ld_d, rw_q, rw_d;
  logic [4:0]      wn_q, wn_d;
  logic            err_q, err_d, mis_q, mis_d;

  logic [2:0]      al_f3_c;
  logic [1:0]      al_lane_c;
  logic [XLEN-1:0] ld_ext_c, sdat_c;
  logic [3:0]      sel_c;
  logic            misalign_c;
  logic            is_mem_c;
  logic            bus_err_c;

`ifdef MEM_MISALIGN_EN
  assign misalign_c = is_misaligned(ex_funct3, ex_aluresult[1:0]);
`else
  assign misalign_c = 1'b0;
`endif

  assign is_mem_c  = ex_mem_load | ex_mem_store;
  assign bus_err_c = dbus_err_i;

  // One aligner serves both paths: store formatting at issue, load extraction while in BUS.
  assign al_f3_c   = (state_q == IDLE) ? ex_funct3 : f3_q;
  assign al_lane_c = (state_q == IDLE) ? ex_aluresult[1:0] : addr_q[1:0];

  mem_align u_align (
    .funct3_i     (al_f3_c),
    .lane_i       (al_lane_c),
    .store_data_i (ex_store_data),
    .load_data_i  (dbus_dat_i),
    .load_ext_o   (ld_ext_c),
    .sel_o        (sel_c),
    .store_dat_o  (sdat_c)
  );

  always_comb begin
    state_d     = state_q;
    wb_d        = wb_q;
    wb_d.valid  = 1'b0;
    wb_d.reg_wr = 1'b0;
    cyc_d       = cyc_q;
    we_d        = we_q;
    badr_d      = badr_q;
    bdat_d      = bdat_q;
    bsel_d      = bsel_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    f3_d        = f3_q;
    ld_d        = ld_q;
    rw_d        = rw_q;
    wn_d        = wn_q;
    err_d       = 1'b0;
    mis_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!is_mem_c || misalign_c) begin
            wb_d.valid     = 1'b1;
            wb_d.reg_wr    = ex_reg_wr & ~is_mem_c;
            wb_d.reg_wnum  = ex_reg_wnum;
            wb_d.mem_load  = 1'b0;
            wb_d.mem_dat   = '0;
            wb_d.aluresult = ex_aluresult;
            wb_d.data_out  = ex_data_out;
            mis_d          = misalign_c;
          end else begin
            state_d = BUS;
            cyc_d   = 1'b1;
            we_d    = ex_mem_store;
            badr_d  = {ex_aluresult[XLEN-1:2], 2'b00};
            bsel_d  = sel_c;
            bdat_d  = ex_mem_store ? sdat_c : '0;
            addr_d  = ex_aluresult;
            dout_d  = ex_data_out;
            f3_d    = ex_funct3;
            ld_d    = ex_mem_load;
            rw_d    = ex_reg_wr;
            wn_d    = ex_reg_wnum;
          end
        end
      end
      BUS: begin
        // err wins over ack when both terminate the cycle together.
        if (dbus_ack_i || dbus_err_i) begin
          state_d        = IDLE;
          cyc_d          = 1'b0;
          we_d           = 1'b0;
          badr_d         = '0;
          bsel_d         = '0;
          bdat_d         = '0;
          wb_d.valid     = 1'b1;
          wb_d.reg_wr    = ld_q & rw_q & ~bus_err_c;
          wb_d.reg_wnum  = wn_q;
          wb_d.mem_load  = ld_q & ~bus_err_c;
          wb_d.mem_dat   = (ld_q && !bus_err_c) ? ld_ext_c : '0;
          wb_d.aluresult = addr_q;
          wb_d.data_out  = dout_q;
          err_d          = bus_err_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wb_q    <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      badr_q  <= '0;
      bdat_q  <= '0;
      bsel_q  <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      f3_q    <= '0;
      ld_q    <= 1'b0;
      rw_q    <= 1'b0;
      wn_q    <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      badr_q  <= badr_d;
      bdat_q  <= bdat_d;
      bsel_q  <= bsel_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      f3_q    <= f3_d;
      ld_q    <= ld_d;
      rw_q    <= rw_d;
      wn_q    <= wn_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  assign ex_ready       = (state_q == IDLE);
  assign wb_valid       = wb_q.valid;
  assign wb_reg_wr      = wb_q.reg_wr;
  assign wb_reg_wnum    = wb_q.reg_wnum;
  assign wb_mem_load    = wb_q.mem_load;
  assign wb_mem_dat_i_w = wb_q.mem_dat;
  assign wb_aluresult   = wb_q.aluresult;
  assign wb_data_out    = wb_q.data_out;
  assign dbus_cyc_o     = cyc_q;
  assign dbus_stb_o     = cyc_q;
  assign dbus_we_o      = we_q;
  assign dbus_adr_o     = badr_q;
  assign dbus_dat_o     = bdat_q;
  assign dbus_sel_o     = bsel_q;
  assign bus_err_o      = err_q;
  assign misalign_o     = mis_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu against a transaction-level model of the access rules.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_aluresult, ex_store_data, ex_data_out;
  logic        ex_mem_load, ex_mem_store;
  logic [2:0]  ex_funct3;
  logic        ex_reg_wr;
  logic [4:0]  ex_reg_wnum;
  logic        wb_valid, wb_reg_wr, wb_mem_load;
  logic [4:0]  wb_reg_wnum;
  logic [31:0] wb_mem_dat_i_w, wb_aluresult, wb_data_out;
  logic        dbus_cyc_o, dbus_stb_o, dbus_we_o;
  logic [31:0] dbus_adr_o, dbus_dat_o, dbus_dat_i;
  logic [3:0]  dbus_sel_o;
  logic        dbus_ack_i, dbus_err_i, bus_err_o, misalign_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_alu;

  mem_lsu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_aluresult(ex_aluresult), .ex_store_data(ex_store_data), .ex_data_out(ex_data_out),
    .ex_mem_load(ex_mem_load), .ex_mem_store(ex_mem_store), .ex_funct3(ex_funct3),
    .ex_reg_wr(ex_reg_wr), .ex_reg_wnum(ex_reg_wnum),
    .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr), .wb_reg_wnum(wb_reg_wnum),
    .wb_mem_load(wb_mem_load), .wb_mem_dat_i_w(wb_mem_dat_i_w),
    .wb_aluresult(wb_aluresult), .wb_data_out(wb_data_out),
    .dbus_cyc_o(dbus_cyc_o), .dbus_stb_o(dbus_stb_o), .dbus_we_o(dbus_we_o),
    .dbus_adr_o(dbus_adr_o), .dbus_dat_o(dbus_dat_o), .dbus_sel_o(dbus_sel_o),
    .dbus_dat_i(dbus_dat_i), .dbus_ack_i(dbus_ack_i), .dbus_err_i(dbus_err_i),
    .bus_err_o(bus_err_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Access size in bytes; anything that is not byte or half is a word.
  function automatic int unsigned acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Byte offset within the word, rounded down to the access size.
  function automatic int unsigned acc_off(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz = acc_size(f3);
    return ((addr % 4) / sz) * sz;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    int unsigned sz = acc_size(f3);
    logic [31:0] v = word >> (8 * acc_off(f3, addr));
    if (sz == 1) begin
      v = v & 32'h0000_00FF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'h0000_FFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_sel(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned m = ((32'd1 << acc_size(f3)) - 1) << acc_off(f3, addr);
    return 32'(m[3:0]);
  endfunction

  function automatic logic [31:0] ref_sdat(input logic [2:0] f3, input logic [31:0] sd);
    int unsigned sz = acc_size(f3);
    if (sz == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
`ifdef MEM_MISALIGN_EN
    return (acc_size(f3) == 2 && addr[0]) || (acc_size(f3) == 4 && addr[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_wb_valid", 32'(wb_valid), 32'd0);
      chk("idle_wb_reg_wr", 32'(wb_reg_wr), 32'd0);
      chk("idle_bus_err", 32'(bus_err_o), 32'd0);
      chk("idle_cyc", 32'(dbus_cyc_o), 32'd0);
      chk("idle_alu_hold", wb_aluresult, last_alu);
    end
  endtask

  // Present one instruction, play the bus slave, and check bus and WB against the model.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] dout,
                       input logic rw, input logic [4:0] wn, input int waits,
                       input logic err, input logic ack_too, input logic [31:0] rdat);
    int lowc;
    logic mem;
    logic mis;
    mem = ld | st;
    mis = mem && ref_misaligned(f3, addr);
    @(negedge clk);
    chk("ready_before", 32'(ex_ready), 32'd1);
    ex_valid = 1'b1; ex_mem_load = ld; ex_mem_store = st; ex_funct3 = f3;
    ex_aluresult = addr; ex_store_data = sd; ex_data_out = dout;
    ex_reg_wr = rw; ex_reg_wnum = wn;
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0; ex_mem_load = 1'b0; ex_mem_store = 1'b0;
    ex_aluresult = $urandom; ex_store_data = $urandom;
    last_alu = addr;
    if (!mem || mis) begin
      chk("pass_wb_valid", 32'(wb_valid), 32'd1);
      chk("pass_wb_reg_wr", 32'(wb_reg_wr), 32'(rw & ~mem));
      chk("pass_wb_wnum", 32'(wb_reg_wnum), 32'(wn));
      chk("pass_wb_alu", wb_aluresult, addr);
      chk("pass_wb_dout", wb_data_out, dout);
      chk("pass_wb_mem_load", 32'(wb_mem_load), 32'd0);
      chk("pass_misalign", 32'(misalign_o), 32'(mis));
      chk("pass_no_cyc", 32'(dbus_cyc_o), 32'd0);
      chk("pass_ready", 32'(ex_ready), 32'd1);
      return;
    end
    chk("bus_cyc", 32'(dbus_cyc_o), 32'd1);
    chk("bus_stb", 32'(dbus_stb_o), 32'd1);
    chk("bus_we", 32'(dbus_we_o), 32'(st));
    chk("bus_adr", dbus_adr_o, {addr[31:2], 2'b00});
    chk("bus_sel", 32'(dbus_sel_o), ref_sel(f3, addr));
    if (st) chk("bus_dat", dbus_dat_o, ref_sdat(f3, sd));
    chk("bubble_wb_valid", 32'(wb_valid), 32'd0);
    chk("bubble_wb_reg_wr", 32'(wb_reg_wr), 32'd0);
    chk("bus_misalign", 32'(misalign_o), 32'd0);
    lowc = ex_ready ? 0 : 1;
    for (int i = 0; i < waits; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!ex_ready) lowc++;
      chk("wait_cyc", 32'(dbus_cyc_o), 32'd1);
      chk("wait_adr", dbus_adr_o, {addr[31:2], 2'b00});
      chk("wait_wb_valid", 32'(wb_valid), 32'd0);
    end
    dbus_dat_i = rdat; dbus_err_i = err; dbus_ack_i = !err || ack_too;
    @(posedge clk);
    @(negedge clk);
    dbus_ack_i = 1'b0; dbus_err_i = 1'b0; dbus_dat_i = $urandom;
    chk("ready_low_cycles", 32'(lowc), 32'(waits + 1));
    chk("done_cyc", 32'(dbus_cyc_o), 32'd0);
    chk("done_stb", 32'(dbus_stb_o), 32'd0);
    chk("done_ready", 32'(ex_ready), 32'd1);
    chk("done_wb_valid", 32'(wb_valid), 32'd1);
    chk("done_wb_reg_wr", 32'(wb_reg_wr), 32'(ld & rw & ~err));
    chk("done_wb_mem_load", 32'(wb_mem_load), 32'(ld & ~err));
    if (ld) chk("done_load_data", wb_mem_dat_i_w, err ? 32'd0 : ref_load(f3, addr, rdat));
    chk("done_wb_wnum", 32'(wb_reg_wnum), 32'(wn));
    chk("done_wb_alu", wb_aluresult, addr);
    chk("done_wb_dout", wb_data_out, dout);
    chk("done_bus_err", 32'(bus_err_o), 32'(err));
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_mem_load = 1'b0; ex_mem_store = 1'b0;
    ex_funct3 = 3'd0; ex_aluresult = '0; ex_store_data = '0; ex_data_out = '0;
    ex_reg_wr = 1'b0; ex_reg_wnum = '0;
    dbus_dat_i = '0; dbus_ack_i = 1'b0; dbus_err_i = 1'b0;
    last_alu = '0;
    repeat (2) @(negedge clk);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_cyc", 32'(dbus_cyc_o), 32'd0);
    chk("rst_alu", wb_aluresult, 32'd0);
    chk("rst_bus_err", 32'(bus_err_o), 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    rst_n = 1'b1;

    // ALU pass-through
    issue(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 32'hCAFE_0001, 1'b1, 5'd5, 0, 1'b0, 1'b0, 32'h0);
    idle_cycles(1);
    // LB at 0x103, two wait states
    issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h11, 1'b1, 5'd7, 2, 1'b0, 1'b0, 32'h80FF_FF00);
    chk("lb_value", wb_mem_dat_i_w, 32'hFFFF_FF80);
    // SH at 0x202, zero wait
    issue(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 32'h22, 1'b1, 5'd8, 0, 1'b0, 1'b0, 32'h0);
    // LW at 0x300 with err and ack together
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h33, 1'b1, 5'd9, 1, 1'b1, 1'b1, 32'h1357_9BDF);
    idle_cycles(1);

    // Reset in the middle of a bus cycle
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_load = 1'b1; ex_funct3 = 3'b010; ex_aluresult = 32'h500;
    ex_reg_wr = 1'b1; ex_reg_wnum = 5'd3;
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0; ex_mem_load = 1'b0;
    chk("rstbus_cyc_before", 32'(dbus_cyc_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstbus_cyc", 32'(dbus_cyc_o), 32'd0);
    chk("rstbus_stb", 32'(dbus_stb_o), 32'd0);
    chk("rstbus_adr", dbus_adr_o, 32'd0);
    chk("rstbus_alu", wb_aluresult, 32'd0);
    chk("rstbus_ready", 32'(ex_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    last_alu = '0;
    issue(1'b0, 1'b0, 3'b000, 32'hABCD, 32'h0, 32'h44, 1'b1, 5'd12, 0, 1'b0, 1'b0, 32'h0);

    // LW at 0x402: trapped or issued with the low bits ignored
    issue(1'b1, 1'b0, 3'b010, 32'h402, 32'h0, 32'h55, 1'b1, 5'd13, 1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    idle_cycles(1);

    for (int n = 0; n < 250; n++) begin
      int unsigned op;
      op = $urandom_range(0, 2);
      issue(op == 1, op == 2, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom_range(0, 3),
            $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycles(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
